addsub_sequencer: RTL and testbench

Command sequencer and result register for the 16-bit adder-subtractor. It accepts one operation per valid/ready handshake and drives the combinational `addersubstractor16bit` datapath. After a programmable settle time it captures the sum and flags into registers and holds them on a valid/ready result port. It also keeps a 16-bit accumulator for chained add/subtract.

---
 rtl/addsub_sequencer_if.sv | 41 ++++
 rtl/addsub_sequencer.sv | 98 +++++++++
 tb/tb_addsub_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_sequencer_if.sv
// Bundle of command, result, accumulator and adder-datapath signals for addsub_sequencer.
// The slave modport is the sequencer; the master modport is the host plus the adder.
interface addsub_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic        cmd_signed;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        acc_clr;
  logic [15:0] as_input1;
  logic [15:0] as_input2;
  logic        as_I;
  logic        as_S;
  logic [15:0] as_sum;
  logic        as_outc;
  logic        as_overflow;
  logic        as_borrow;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_sum;
  logic        res_carry;
  logic        res_overflow;
  logic        res_borrow;
  logic        res_zero;
  logic [15:0] acc;

  modport slave (
    input  cmd_valid, cmd_op, cmd_signed, cmd_a, cmd_b, acc_clr, res_ready,
    input  as_sum, as_outc, as_overflow, as_borrow,
    output cmd_ready, as_input1, as_input2, as_I, as_S,
    output res_valid, res_sum, res_carry, res_overflow, res_borrow, res_zero, acc
  );

  modport master (
    output cmd_valid, cmd_op, cmd_signed, cmd_a, cmd_b, acc_clr, res_ready,
    output as_sum, as_outc, as_overflow, as_borrow,
    input  cmd_ready, as_input1, as_input2, as_I, as_S,
    input  res_valid, res_sum, res_carry, res_overflow, res_borrow, res_zero, acc
  );
endinterface

// File: rtl/addsub_sequencer.sv
// Command sequencer for the 16-bit adder-subtractor: holds operands for a settle period,
// captures sum/flags into a result register, and maintains a chained accumulator.
module addsub_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input logic                clk,
  input logic                rst_n,
  addsub_sequencer_if.slave  bus_io
);

  typedef enum logic [1:0] {StIdle, StDrive, StCapture, StHold} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        acc_op_q;
  logic [15:0] in1_q, in2_q;
  logic        inv_q, sgn_q;
  logic        res_valid_q;
  logic [15:0] res_sum_q;
  logic        res_carry_q, res_ovf_q, res_borrow_q, res_zero_q;
  logic [15:0] acc_q;

  logic cmd_ready;
  logic accept;

  // HOLD can take a new command only in the cycle its result is being retired.
  assign cmd_ready = (state_q == StIdle) || ((state_q == StHold) && bus_io.res_ready);
  assign accept    = bus_io.cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      acc_op_q     <= 1'b0;
      in1_q        <= '0;
      in2_q        <= '0;
      inv_q        <= 1'b0;
      sgn_q        <= 1'b0;
      res_valid_q  <= 1'b0;
      res_sum_q    <= '0;
      res_carry_q  <= 1'b0;
      res_ovf_q    <= 1'b0;
      res_borrow_q <= 1'b0;
      res_zero_q   <= 1'b0;
      acc_q        <= '0;
    end else begin
      if (accept) begin
        in1_q    <= bus_io.cmd_op[1] ? acc_q : bus_io.cmd_a;
        in2_q    <= bus_io.cmd_op[1] ? bus_io.cmd_a : bus_io.cmd_b;
        inv_q    <= bus_io.cmd_op[0];
        sgn_q    <= bus_io.cmd_signed;
        acc_op_q <= bus_io.cmd_op[1];
        cnt_q    <= '0;
        state_q  <= StDrive;
      end
      case (state_q)
        StIdle: ;
        StDrive: begin
          if (cnt_q == 4'(SETTLE_CYCLES - 1)) state_q <= StCapture;
          else                                 cnt_q   <= cnt_q + 4'd1;
        end
        StCapture: begin
          res_sum_q    <= bus_io.as_sum;
          res_carry_q  <= bus_io.as_outc;
          res_ovf_q    <= bus_io.as_overflow;
          res_borrow_q <= bus_io.as_borrow;
          res_zero_q   <= (bus_io.as_sum == 16'h0000);
          res_valid_q  <= 1'b1;
          if (acc_op_q) acc_q <= bus_io.as_sum;
          state_q      <= StHold;
        end
        StHold: begin
          if (bus_io.res_ready) begin
            res_valid_q <= 1'b0;
            if (!accept) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
      // Clear takes priority over an accumulator load in the same cycle.
      if (bus_io.acc_clr) acc_q <= '0;
    end
  end

  assign bus_io.cmd_ready    = cmd_ready;
  assign bus_io.as_input1    = in1_q;
  assign bus_io.as_input2    = in2_q;
  assign bus_io.as_I         = inv_q;
  assign bus_io.as_S         = sgn_q;
  assign bus_io.res_valid    = res_valid_q;
  assign bus_io.res_sum      = res_sum_q;
  assign bus_io.res_carry    = res_carry_q;
  assign bus_io.res_overflow = res_ovf_q;
  assign bus_io.res_borrow   = res_borrow_q;
  assign bus_io.res_zero     = res_zero_q;
  assign bus_io.acc          = acc_q;

endmodule

// File: tb/tb_addsub_sequencer.sv
// Self-checking bench for addsub_sequencer: behavioural adder, scoreboard of expected
// results checked at each result handshake, plus per-scenario inline checks.
module tb_addsub_sequencer;

  typedef struct packed {
    logic [15:0] sum;
    logic        c;
    logic        ov;
    logic        b;
    logic        z;
    logic [15:0] acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  exp_t sb[$];
  logic [15:0] model_acc;

  addsub_sequencer_if bus ();

  addsub_sequencer #(.SETTLE_CYCLES(1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {outc, overflow, borrow, sum}.
  function automatic logic [18:0] adder(input logic [15:0] a, input logic [15:0] b,
                                        input logic i, input logic s);
    logic [15:0] bx;
    logic [16:0] r;
    logic        ov;
    bx = b ^ {16{i}};
    r  = {1'b0, a} + {1'b0, bx} + 17'(i);
    ov = s & (a[15] == bx[15]) & (r[15] != a[15]);
    return {r[16], ov, i & ~s & ~r[16], r[15:0]};
  endfunction

  always_comb begin
    logic [18:0] r;
    r = adder(bus.as_input1, bus.as_input2, bus.as_I, bus.as_S);
    bus.as_outc     = r[18];
    bus.as_overflow = r[17];
    bus.as_borrow   = r[16];
    bus.as_sum      = r[15:0];
  end

  // Scoreboard monitor: every retired result must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e, act;
    #2;
    if (rst_n && bus.res_valid && bus.res_ready) begin
      act = {bus.res_sum, bus.res_carry, bus.res_overflow, bus.res_borrow, bus.res_zero,
             bus.acc};
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got %h, required no result", act);
      end else begin
        e = sb.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL result: got sum=%h c=%b ov=%b b=%b z=%b acc=%h, required sum=%h c=%b ov=%b b=%b z=%b acc=%h",
                   act.sum, act.c, act.ov, act.b, act.z, act.acc,
                   e.sum, e.c, e.ov, e.b, e.z, e.acc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_cmd(input logic [1:0] op, input logic s, input logic [15:0] a,
                        input logic [15:0] b, input bit clr_cap);
    logic [18:0] r;
    exp_t        e;
    r = op[1] ? adder(model_acc, a, op[0], s) : adder(a, b, op[0], s);
    e.sum = r[15:0];
    e.c   = r[18];
    e.ov  = r[17];
    e.b   = r[16];
    e.z   = (r[15:0] == 16'h0000);
    e.acc = clr_cap ? 16'h0000 : (op[1] ? r[15:0] : model_acc);
    model_acc = e.acc;
    sb.push_back(e);
    bus.cmd_op     = op;
    bus.cmd_signed = s;
    bus.cmd_a      = a;
    bus.cmd_b      = b;
    bus.cmd_valid  = 1'b1;
    for (int i = 0; i < 40 && bus.cmd_ready !== 1'b1; i++) @(negedge clk);
    if (bus.cmd_ready !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: cmd_ready=%b, required 1", bus.cmd_ready);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    bus.res_ready = 1'b1;
    for (int i = 0; i < 40 && bus.res_valid !== 1'b1; i++) @(negedge clk);
    if (bus.res_valid !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("FAIL result_timeout: res_valid=%b, required 1", bus.res_valid);
    end
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.cmd_ready, bus.res_valid, bus.res_zero} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_handshake: got ready/valid/zero=%b, required 100",
               {bus.cmd_ready, bus.res_valid, bus.res_zero});
    end
    n_cmp++;
    if ({bus.res_sum, bus.res_carry, bus.res_overflow, bus.res_borrow, bus.acc} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_result: got sum=%h acc=%h, required 0", bus.res_sum, bus.acc);
    end
    n_cmp++;
    if ({bus.as_input1, bus.as_input2, bus.as_I, bus.as_S} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_adder_in: got in1=%h in2=%h I=%b S=%b, required 0",
               bus.as_input1, bus.as_input2, bus.as_I, bus.as_S);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    bus.cmd_op = 2'b00; bus.cmd_signed = 1'b0;
    bus.cmd_a = 16'h0001; bus.cmd_b = 16'h0002; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n_cmp++;
    if ({bus.as_input1, bus.as_input2} !== {16'h0001, 16'h0002}) begin
      n_fail++;
      $display("FAIL midop_drive: got in1=%h in2=%h, required 0001 0002",
               bus.as_input1, bus.as_input2);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.as_input1, bus.as_input2, bus.cmd_ready, bus.res_valid} !== {32'd0, 2'b10}) begin
      n_fail++;
      $display("FAIL midop_async_reset: got in1=%h in2=%h ready=%b valid=%b, required 0 0 1 0",
               bus.as_input1, bus.as_input2, bus.cmd_ready, bus.res_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen || bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_no_result: got res_valid_seen=%b ready=%b, required 0 1",
               seen, bus.cmd_ready);
    end
  endtask

  task automatic test_carry();
    logic [2:0] v;
    do_cmd(2'b00, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
    v[0] = bus.res_valid;
    @(negedge clk);
    v[1] = bus.res_valid;
    @(negedge clk);
    v[2] = bus.res_valid;
    n_cmp++;
    if (v !== 3'b100) begin
      n_fail++;
      $display("FAIL carry_latency: got res_valid after edges N+2..N=%b, required 100", v);
    end
    n_cmp++;
    if ({bus.res_sum, bus.res_carry, bus.res_zero, bus.res_overflow, bus.res_borrow} !==
        {16'h0000, 4'b1100}) begin
      n_fail++;
      $display("FAIL carry_flags: got sum=%h c=%b z=%b ov=%b b=%b, required 0000 1 1 0 0",
               bus.res_sum, bus.res_carry, bus.res_zero, bus.res_overflow, bus.res_borrow);
    end
    drain();
  endtask

  task automatic test_signed_sub();
    do_cmd(2'b01, 1'b1, 16'h8000, 16'h0001, 1'b0);
    n_cmp++;
    if ({bus.as_input1, bus.as_input2, bus.as_I, bus.as_S} !== {16'h8000, 16'h0001, 2'b11}) begin
      n_fail++;
      $display("FAIL sub_adder_in: got in1=%h in2=%h I=%b S=%b, required 8000 0001 1 1",
               bus.as_input1, bus.as_input2, bus.as_I, bus.as_S);
    end
    drain();
    do_cmd(2'b01, 1'b0, 16'h0003, 16'h0005, 1'b0);
    drain();
  endtask

  task automatic test_accumulate();
    logic [15:0] want [3];
    want[0] = 16'h1234; want[1] = 16'h1334; want[2] = 16'h1300;
    bus.acc_clr = 1'b1;
    @(negedge clk);
    bus.acc_clr = 1'b0;
    model_acc = 16'h0000;
    n_cmp++;
    if (bus.acc !== 16'h0000) begin
      n_fail++;
      $display("FAIL acc_clear: got %h, required 0000", bus.acc);
    end
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: do_cmd(2'b10, 1'b0, 16'h1234, 16'hDEAD, 1'b0);
        1: do_cmd(2'b10, 1'b0, 16'h0100, 16'hDEAD, 1'b0);
        default: do_cmd(2'b11, 1'b0, 16'h0034, 16'hDEAD, 1'b0);
      endcase
      drain();
      n_cmp++;
      if (bus.acc !== want[k]) begin
        n_fail++;
        $display("FAIL acc_step%0d: got %h, required %h", k, bus.acc, want[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [18:0] r;
    exp_t        e;
    bit          bad;
    do_cmd(2'b00, 1'b0, 16'h1111, 16'h2222, 1'b0);
    for (int i = 0; i < 40 && bus.res_valid !== 1'b1; i++) @(negedge clk);
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b1 || bus.res_sum !== 16'h3333 || bus.cmd_ready !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_fail++;
      $display("FAIL backpressure_hold: got valid=%b sum=%h ready=%b, required 1 3333 0",
               bus.res_valid, bus.res_sum, bus.cmd_ready);
    end
    r = adder(16'h0010, 16'h0020, 1'b0, 1'b0);
    e = {r[15:0], r[18], r[17], r[16], r[15:0] == 16'h0, model_acc};
    sb.push_back(e);
    bus.cmd_op = 2'b00; bus.cmd_signed = 1'b0;
    bus.cmd_a = 16'h0010; bus.cmd_b = 16'h0020;
    bus.res_ready = 1'b1;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b0;
    n_cmp++;
    if ({bus.res_valid, bus.as_input1, bus.as_input2} !== {1'b0, 16'h0010, 16'h0020}) begin
      n_fail++;
      $display("FAIL backpressure_same_edge: got valid=%b in1=%h in2=%h, required 0 0010 0020",
               bus.res_valid, bus.as_input1, bus.as_input2);
    end
    drain();
    n_cmp++;
    if (bus.res_sum !== 16'h0030) begin
      n_fail++;
      $display("FAIL backpressure_second: got %h, required 0030", bus.res_sum);
    end
  endtask

  task automatic test_back_to_back();
    int          acc_cyc[$];
    logic [18:0] r;
    exp_t        e;
    bus.res_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bus.cmd_op = 2'b00; bus.cmd_signed = 1'b0;
      bus.cmd_a = 16'(c * 16'h0101); bus.cmd_b = 16'hF0F0;
      bus.cmd_valid = 1'b1;
      if (bus.cmd_ready === 1'b1) begin
        r = adder(bus.cmd_a, bus.cmd_b, 1'b0, 1'b0);
        e = {r[15:0], r[18], r[17], r[16], r[15:0] == 16'h0, model_acc};
        sb.push_back(e);
        acc_cyc.push_back(c);
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    drain();
    n_cmp++;
    if (acc_cyc.size() != 4 || acc_cyc[1] - acc_cyc[0] != 3) begin
      n_fail++;
      $display("FAIL b2b_throughput: got %0d accepts spacing %0d, required 4 spacing 3",
               acc_cyc.size(), acc_cyc.size() > 1 ? acc_cyc[1] - acc_cyc[0] : -1);
    end
  endtask

  task automatic test_clear_collision();
    bus.acc_clr = 1'b1;
    @(negedge clk);
    bus.acc_clr = 1'b0;
    model_acc = 16'h0000;
    do_cmd(2'b10, 1'b0, 16'h0005, 16'h0000, 1'b0);
    drain();
    do_cmd(2'b10, 1'b0, 16'h0003, 16'h0000, 1'b1);
    @(negedge clk);
    bus.acc_clr = 1'b1;
    @(negedge clk);
    bus.acc_clr = 1'b0;
    n_cmp++;
    if ({bus.res_valid, bus.res_sum, bus.acc} !== {1'b1, 16'h0008, 16'h0000}) begin
      n_fail++;
      $display("FAIL clear_collision: got valid=%b sum=%h acc=%h, required 1 0008 0000",
               bus.res_valid, bus.res_sum, bus.acc);
    end
    drain();
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    model_acc = 16'h0000;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_signed = 1'b0;
    bus.cmd_a = 16'h0; bus.cmd_b = 16'h0; bus.acc_clr = 1'b0; bus.res_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_reset_mid_op();
    test_carry();
    test_signed_sub();
    test_accumulate();
    test_backpressure();
    test_back_to_back();
    test_clear_collision();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
